// File: rtl/hpi_responder.sv
`default_nettype none
// ============================================================================
// Module  : hpi_responder
// Brief   : Device end of the 16-bit HPI bus: auto-incrementing pointer memory,
//           bidirectional mailboxes, status register and a device-side port.
// Revision: 1.0 - initial release
// ============================================================================
module hpi_responder #(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [1:0]        hpi_address,
  input  logic              hpi_cs_n,
  input  logic              hpi_r_n,
  input  logic              hpi_w_n,
  input  logic              hpi_reset_n,
  input  logic [15:0]       hpi_data_in,
  output logic [15:0]       hpi_data_out,
  output logic              hpi_irq,
  output logic [15:0]       dev_mbx_rx_data,
  output logic              dev_mbx_rx_valid,
  input  logic              dev_mbx_rx_ack,
  input  logic [15:0]       dev_mbx_tx_data,
  input  logic              dev_mbx_tx_valid,
  output logic              dev_mbx_tx_ready,
  input  logic [ADDR_W-1:0] dev_mem_addr,
  input  logic              dev_mem_we,
  input  logic [15:0]       dev_mem_wdata,
  output logic [15:0]       dev_mem_rdata
);

  localparam logic [1:0] C_REG_DATA = 2'd0;
  localparam logic [1:0] C_REG_MBX  = 2'd1;
  localparam logic [1:0] C_REG_ADDR = 2'd2;
  localparam logic [1:0] C_REG_STAT = 2'd3;
  localparam int         C_DEPTH    = 1 << ADDR_W;

  // Power-up contents only; neither reset source touches the array.
  logic [15:0] r_mem [C_DEPTH] = '{default: (INIT_ZERO ? 16'h0000 : 16'hxxxx)};

  logic [15:0]       r_ptr;
  logic              r_rd_act_q;
  logic              r_wr_act_q;
  logic [15:0]       r_h2d_reg;
  logic              r_h2d_valid;
  logic [15:0]       r_d2h_reg;
  logic              r_d2h_full;
  logic              r_err;
  logic              r_ovr;
  logic              r_rd_pend;
  logic              r_rd_is_data;
  logic [15:0]       r_rd_word;
  logic [15:0]       r_hpi_mem_q;

  logic              w_clr;
  logic              w_rd_act;
  logic              w_wr_act;
  logic              w_conflict;
  logic              w_rd_evt;
  logic              w_wr_evt;
  logic              w_wr_ptr;
  logic              w_wr_data;
  logic              w_wr_mbx;
  logic              w_rd_mbx;
  logic              w_rd_stat;
  logic              w_ptr_inc;
  logic              w_tx_acc;
  logic [ADDR_W-1:0] w_mem_idx;

  assign w_clr      = reset_reset | ~hpi_reset_n;
  assign w_rd_act   = ~hpi_cs_n & ~hpi_r_n;
  assign w_wr_act   = ~hpi_cs_n & ~hpi_w_n;
  assign w_conflict = w_rd_act & w_wr_act & ~w_clr;

  // One event per strobe assertion; simultaneous r/w strobes never access.
  assign w_rd_evt   = w_rd_act & ~r_rd_act_q & ~w_wr_act & ~w_clr;
  assign w_wr_evt   = w_wr_act & ~r_wr_act_q & ~w_rd_act & ~w_clr;

  assign w_wr_ptr   = w_wr_evt & (hpi_address == C_REG_ADDR);
  assign w_wr_data  = w_wr_evt & (hpi_address == C_REG_DATA);
  assign w_wr_mbx   = w_wr_evt & (hpi_address == C_REG_MBX);
  assign w_rd_mbx   = w_rd_evt & (hpi_address == C_REG_MBX);
  assign w_rd_stat  = w_rd_evt & (hpi_address == C_REG_STAT);
  assign w_ptr_inc  = (w_rd_evt | w_wr_evt) & (hpi_address == C_REG_DATA);
  assign w_mem_idx  = r_ptr[ADDR_W:1];

  // Ready also rises in the cycle the host drains the mailbox, so a word
  // offered then replaces the one being read out.
  assign dev_mbx_tx_ready = ~r_d2h_full | w_rd_mbx;
  assign w_tx_acc         = dev_mbx_tx_valid & dev_mbx_tx_ready;

  assign hpi_irq          = r_d2h_full;
  assign dev_mbx_rx_valid = r_h2d_valid;
  assign dev_mbx_rx_data  = r_h2d_reg;

  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      r_ptr        <= '0;
      r_rd_act_q   <= 1'b0;
      r_wr_act_q   <= 1'b0;
      r_h2d_reg    <= '0;
      r_h2d_valid  <= 1'b0;
      r_d2h_reg    <= '0;
      r_d2h_full   <= 1'b0;
      r_err        <= 1'b0;
      r_ovr        <= 1'b0;
      r_rd_pend    <= 1'b0;
      r_rd_is_data <= 1'b0;
      r_rd_word    <= '0;
      hpi_data_out <= '0;
    end else begin
      r_rd_act_q <= w_rd_act;
      r_wr_act_q <= w_wr_act;

      if (w_wr_ptr) begin
        r_ptr <= {hpi_data_in[15:1], 1'b0};
      end else if (w_ptr_inc) begin
        r_ptr <= r_ptr + 16'd2;
      end

      if (w_wr_mbx) begin
        r_h2d_reg   <= hpi_data_in;
        r_h2d_valid <= 1'b1;
      end else if (dev_mbx_rx_ack) begin
        r_h2d_valid <= 1'b0;
      end

      if (w_tx_acc) begin
        r_d2h_reg  <= dev_mbx_tx_data;
        r_d2h_full <= 1'b1;
      end else if (w_rd_mbx) begin
        r_d2h_full <= 1'b0;
      end

      if (w_rd_stat) begin
        r_err <= 1'b0;
        r_ovr <= 1'b0;
      end
      if (w_conflict) begin
        r_err <= 1'b1;
      end
      if (w_wr_mbx && r_h2d_valid && !dev_mbx_rx_ack) begin
        r_ovr <= 1'b1;
      end

      // Stage 1 snapshots the selected register; stage 2 drives the bus.
      r_rd_pend    <= w_rd_evt;
      r_rd_is_data <= (hpi_address == C_REG_DATA);
      case (hpi_address)
        C_REG_MBX:  r_rd_word <= r_d2h_reg;
        C_REG_ADDR: r_rd_word <= r_ptr;
        C_REG_STAT: r_rd_word <= {12'h000, r_err, r_ovr, r_h2d_valid, r_d2h_full};
        default:    r_rd_word <= '0;
      endcase
      if (r_rd_pend) begin
        hpi_data_out <= r_rd_is_data ? r_hpi_mem_q : r_rd_word;
      end
    end
  end

  // HPI write is issued last so it wins a same-word collision.
  always_ff @(posedge clk_clk) begin
    if (dev_mem_we) begin
      r_mem[dev_mem_addr] <= dev_mem_wdata;
    end
    if (w_wr_data) begin
      r_mem[w_mem_idx] <= hpi_data_in;
    end
    r_hpi_mem_q <= r_mem[w_mem_idx];
  end

  always_ff @(posedge clk_clk) begin
    if (w_clr) begin
      dev_mem_rdata <= '0;
    end else begin
      dev_mem_rdata <= r_mem[dev_mem_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hpi_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_hpi_responder
// Brief   : Directed scoreboard bench for hpi_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hpi_responder;

  localparam int         ADDR_W     = 10;
  localparam logic [1:0] C_REG_DATA = 2'd0;
  localparam logic [1:0] C_REG_MBX  = 2'd1;
  localparam logic [1:0] C_REG_ADDR = 2'd2;
  localparam logic [1:0] C_REG_STAT = 2'd3;

  logic              clk = 1'b0;
  logic              reset_reset;
  logic [1:0]        hpi_address;
  logic              hpi_cs_n;
  logic              hpi_r_n;
  logic              hpi_w_n;
  logic              hpi_reset_n;
  logic [15:0]       hpi_data_in;
  logic [15:0]       hpi_data_out;
  logic              hpi_irq;
  logic [15:0]       dev_mbx_rx_data;
  logic              dev_mbx_rx_valid;
  logic              dev_mbx_rx_ack;
  logic [15:0]       dev_mbx_tx_data;
  logic              dev_mbx_tx_valid;
  logic              dev_mbx_tx_ready;
  logic [ADDR_W-1:0] dev_mem_addr;
  logic              dev_mem_we;
  logic [15:0]       dev_mem_wdata;
  logic [15:0]       dev_mem_rdata;

  hpi_responder #(.ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
    .clk_clk         (clk),
    .reset_reset     (reset_reset),
    .hpi_address     (hpi_address),
    .hpi_cs_n        (hpi_cs_n),
    .hpi_r_n         (hpi_r_n),
    .hpi_w_n         (hpi_w_n),
    .hpi_reset_n     (hpi_reset_n),
    .hpi_data_in     (hpi_data_in),
    .hpi_data_out    (hpi_data_out),
    .hpi_irq         (hpi_irq),
    .dev_mbx_rx_data (dev_mbx_rx_data),
    .dev_mbx_rx_valid(dev_mbx_rx_valid),
    .dev_mbx_rx_ack  (dev_mbx_rx_ack),
    .dev_mbx_tx_data (dev_mbx_tx_data),
    .dev_mbx_tx_valid(dev_mbx_tx_valid),
    .dev_mbx_tx_ready(dev_mbx_tx_ready),
    .dev_mem_addr    (dev_mem_addr),
    .dev_mem_we      (dev_mem_we),
    .dev_mem_wdata   (dev_mem_wdata),
    .dev_mem_rdata   (dev_mem_rdata)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model of the responder's architectural state
  logic [15:0] m_mem [1 << ADDR_W];
  logic [15:0] m_ptr;
  logic [15:0] m_h2d;
  logic        m_h2d_valid;
  logic [15:0] m_d2h;
  logic        m_full;
  logic        m_err;
  logic        m_ovr;
  logic [15:0] sb[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_ptr = '0; m_h2d_valid = 1'b0; m_full = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
    m_h2d = '0; m_d2h = '0;
  endtask

  task automatic hpi_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    hpi_address = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    case (a)
      C_REG_ADDR: m_ptr = {d[15:1], 1'b0};
      C_REG_DATA: begin m_mem[m_ptr[ADDR_W:1]] = d; m_ptr = m_ptr + 16'd2; end
      C_REG_MBX:  begin
        if (m_h2d_valid) m_ovr = 1'b1;
        m_h2d = d; m_h2d_valid = 1'b1;
      end
      default: ;
    endcase
    @(negedge clk);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
  endtask

  task automatic hpi_read(input logic [1:0] a, input string tag,
                          input bit tx_en = 1'b0, input logic [15:0] tx_word = '0);
    logic [15:0] exp;
    @(negedge clk);
    hpi_address = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    case (a)
      C_REG_DATA: begin exp = m_mem[m_ptr[ADDR_W:1]]; m_ptr = m_ptr + 16'd2; end
      C_REG_ADDR: exp = m_ptr;
      C_REG_MBX:  begin exp = m_d2h; m_full = 1'b0; end
      default:    begin
        exp = {12'h000, m_err, m_ovr, m_h2d_valid, m_full};
        m_err = 1'b0; m_ovr = 1'b0;
      end
    endcase
    if (tx_en) begin
      dev_mbx_tx_valid = 1'b1; dev_mbx_tx_data = tx_word;
      m_d2h = tx_word; m_full = 1'b1;
    end
    sb.push_back(exp);
    @(negedge clk);
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; dev_mbx_tx_valid = 1'b0;
    @(negedge clk);
    chk(tag, hpi_data_out, sb.pop_front());
  endtask

  task automatic dev_tx(input logic [15:0] d);
    @(negedge clk);
    dev_mbx_tx_valid = 1'b1; dev_mbx_tx_data = d;
    m_d2h = d; m_full = 1'b1;
    @(negedge clk);
    dev_mbx_tx_valid = 1'b0;
  endtask

  task automatic dev_read(input logic [ADDR_W-1:0] a, input string tag);
    @(negedge clk);
    dev_mem_addr = a;
    @(negedge clk);
    chk(tag, dev_mem_rdata, m_mem[a]);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) m_mem[i] = '0;
    model_clear();
    reset_reset = 1'b1; hpi_reset_n = 1'b1; hpi_address = '0;
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1; hpi_data_in = '0;
    dev_mbx_rx_ack = 1'b0; dev_mbx_tx_data = '0; dev_mbx_tx_valid = 1'b0;
    dev_mem_addr = '0; dev_mem_we = 1'b0; dev_mem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_data_out", hpi_data_out, 16'h0000);
    chk("rst_irq", {15'd0, hpi_irq}, 16'h0000);
    chk("rst_rx_valid", {15'd0, dev_mbx_rx_valid}, 16'h0000);
    chk("rst_tx_ready", {15'd0, dev_mbx_tx_ready}, 16'h0001);
    chk("rst_dev_rdata", dev_mem_rdata, 16'h0000);
    reset_reset = 1'b0;

    // Pointer auto-increment through DATA
    hpi_write(C_REG_ADDR, 16'h0010);
    hpi_write(C_REG_DATA, 16'hAAAA);
    hpi_write(C_REG_DATA, 16'h5555);
    hpi_write(C_REG_ADDR, 16'h0010);
    hpi_read(C_REG_DATA, "data_rd0");
    hpi_read(C_REG_DATA, "data_rd1");
    hpi_read(C_REG_ADDR, "ptr_after_rd");

    // Pointer wrap and aliasing of upper pointer bits
    hpi_write(C_REG_ADDR, 16'hFFFE);
    hpi_write(C_REG_DATA, 16'h1234);
    hpi_read(C_REG_ADDR, "ptr_wrap");
    dev_read({ADDR_W{1'b1}}, "dev_alias_rd");
    hpi_read(C_REG_DATA, "data_at_zero");

    // Host-to-device mailbox, overrun and status clear-on-read
    hpi_write(C_REG_MBX, 16'hBEEF);
    chk("rx_valid_1", {15'd0, dev_mbx_rx_valid}, {15'd0, m_h2d_valid});
    chk("rx_data_1", dev_mbx_rx_data, m_h2d);
    hpi_write(C_REG_MBX, 16'hCAFE);
    hpi_read(C_REG_STAT, "stat_ovr");
    hpi_read(C_REG_STAT, "stat_ovr_clr");
    chk("rx_data_2", dev_mbx_rx_data, m_h2d);
    @(negedge clk); dev_mbx_rx_ack = 1'b1; m_h2d_valid = 1'b0;
    @(negedge clk); dev_mbx_rx_ack = 1'b0;
    chk("rx_valid_ack", {15'd0, dev_mbx_rx_valid}, {15'd0, m_h2d_valid});

    // Device-to-host mailbox and irq
    dev_tx(16'h00C3);
    chk("irq_set", {15'd0, hpi_irq}, {15'd0, m_full});
    chk("tx_ready_full", {15'd0, dev_mbx_tx_ready}, {15'd0, ~m_full});
    hpi_read(C_REG_STAT, "stat_full");
    hpi_read(C_REG_MBX, "mbx_rd");
    chk("irq_clr", {15'd0, hpi_irq}, {15'd0, m_full});
    dev_tx(16'h0011);
    hpi_read(C_REG_MBX, "mbx_rd_race", 1'b1, 16'h0022);
    chk("irq_race", {15'd0, hpi_irq}, {15'd0, m_full});
    hpi_read(C_REG_MBX, "mbx_rd_new");
    chk("irq_clr2", {15'd0, hpi_irq}, {15'd0, m_full});

    // Conflicting strobes: no access, error flag
    @(negedge clk);
    hpi_address = C_REG_DATA; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0; m_err = 1'b1;
    @(negedge clk);
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
    hpi_read(C_REG_ADDR, "ptr_conflict");
    hpi_read(C_REG_STAT, "stat_err");
    hpi_read(C_REG_STAT, "stat_err_clr");
    hpi_read(C_REG_DATA, "mem_conflict");

    // Long strobe gives a single access
    hpi_write(C_REG_ADDR, 16'h0040);
    @(negedge clk);
    hpi_address = C_REG_DATA; hpi_data_in = 16'h7777; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    m_mem[m_ptr[ADDR_W:1]] = 16'h7777; m_ptr = m_ptr + 16'd2;
    repeat (10) @(negedge clk);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    hpi_read(C_REG_ADDR, "ptr_long");
    dev_read(10'h020, "long_wr_word");
    dev_read(10'h021, "long_next_word");

    // Same-word collision: HPI write wins over device write
    hpi_write(C_REG_ADDR, 16'h0060);
    @(negedge clk);
    hpi_address = C_REG_DATA; hpi_data_in = 16'h4444; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    dev_mem_we = 1'b1; dev_mem_addr = 10'h030; dev_mem_wdata = 16'h5555;
    m_mem[m_ptr[ADDR_W:1]] = 16'h4444; m_ptr = m_ptr + 16'd2;
    @(negedge clk);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1; dev_mem_we = 1'b0;
    dev_read(10'h030, "collision");

    // Protocol reset from the host, with an access attempted while low
    hpi_write(C_REG_ADDR, 16'h0100);
    hpi_write(C_REG_MBX, 16'h1111);
    dev_tx(16'h2222);
    @(negedge clk);
    hpi_reset_n = 1'b0; model_clear();
    @(negedge clk);
    hpi_address = C_REG_DATA; hpi_data_in = 16'h9999; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    @(negedge clk);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    @(negedge clk);
    chk("hrst_irq", {15'd0, hpi_irq}, 16'h0000);
    chk("hrst_rx_valid", {15'd0, dev_mbx_rx_valid}, 16'h0000);
    chk("hrst_tx_ready", {15'd0, dev_mbx_tx_ready}, 16'h0001);
    chk("hrst_data_out", hpi_data_out, 16'h0000);
    hpi_reset_n = 1'b1;
    hpi_read(C_REG_ADDR, "hrst_ptr");
    hpi_write(C_REG_ADDR, 16'h0100);
    hpi_read(C_REG_DATA, "hrst_ignored_wr");

    // System reset keeps memory
    hpi_write(C_REG_ADDR, 16'h0200);
    dev_tx(16'h3333);
    @(negedge clk);
    reset_reset = 1'b1; model_clear();
    repeat (2) @(negedge clk);
    chk("srst_irq", {15'd0, hpi_irq}, 16'h0000);
    reset_reset = 1'b0;
    hpi_read(C_REG_ADDR, "srst_ptr");
    hpi_write(C_REG_ADDR, 16'h0010);
    hpi_read(C_REG_DATA, "srst_mem_kept");
    dev_read({ADDR_W{1'b1}}, "srst_dev_kept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
